avmm_burst_writer: RTL

Avalon-MM burst-write initiator in the FPGA fabric. It drives the burst-capable slave port of the LED control component, the side that consumes `beginbursttransfer`. A local command (start address, beat count, seed) produces one Avalon write burst of rotating LED patterns, so fabric logic can animate the LEDs without HPS involvement. It sits beside the HPS in `soc_system` and shares the 50 MHz system clock and reset.

---
 rtl/avmm_burst_pkg.sv | 22 ++
 rtl/avmm_burst_writer_pattern_rotator.sv | 25 ++
 rtl/avmm_burst_writer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/avmm_burst_pkg.sv
// Shared types and helpers for the Avalon-MM burst writer: FSM state
// encoding, the byte-rotate used to animate LED patterns, burst widths.
package avmm_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } burst_state_e;

  localparam int unsigned DEF_MAX_BURST = 8;
  localparam int unsigned DEF_BCNT_W    = $clog2(DEF_MAX_BURST) + 1;

  // Rotate left within a byte; the doubled copy makes the wrap free.
  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] amt);
    logic [15:0] w_dbl;
    w_dbl = {v, v} << amt;
    return w_dbl[15:8];
  endfunction

endpackage

// File: rtl/avmm_burst_writer_pattern_rotator.sv
// Combinational LED pattern generator: seed rotated left by the beat
// index modulo 8.
module pattern_rotator
  import avmm_burst_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [7:0]       i_seed,
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_pattern
);

  logic [2:0] w_amt;

  generate
    if (IDX_W >= 3) begin : g_wide
      assign w_amt = i_idx[2:0];
    end else begin : g_narrow
      assign w_amt = {{(3-IDX_W){1'b0}}, i_idx};
    end
  endgenerate

  assign o_pattern = rotl8(i_seed, w_amt);

endmodule

// File: rtl/avmm_burst_writer.sv
// Avalon-MM burst-write initiator: one local command becomes one write
// burst of rotating LED patterns, with a non-aborting stall watchdog.
module avmm_burst_writer
  import avmm_burst_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 8,
  parameter int STALL_LIMIT = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_W-1:0]              cmd_addr,
  input  logic [$clog2(MAX_BURST):0]     cmd_len,
  input  logic [7:0]                     cmd_seed,
  output logic [ADDR_W-1:0]              avm_address,
  output logic                           avm_write,
  output logic [DATA_W-1:0]              avm_writedata,
  output logic [DATA_W/8-1:0]            avm_byteenable,
  output logic [$clog2(MAX_BURST):0]     avm_burstcount,
  output logic                           avm_beginbursttransfer,
  input  logic                           avm_waitrequest,
  output logic                           done,
  output logic                           err_len,
  output logic                           stall_flag,
  output burst_state_e                   o_dbg_state
);

  localparam int IDX_W  = $clog2(MAX_BURST);
  localparam int BCNT_W = IDX_W + 1;
  localparam int SC_W   = $clog2(STALL_LIMIT + 1);

  // Handshakes: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; a beat transfers on a rising edge where
  // avm_write is high and avm_waitrequest is low. Nothing else moves data.

  burst_state_e      r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [BCNT_W-1:0] r_len,        w_len_nxt;
  logic [7:0]        r_seed,       w_seed_nxt;
  logic [IDX_W-1:0]  r_beat,       w_beat_nxt;
  logic [7:0]        r_data,       w_data_nxt;
  logic              r_write,      w_write_nxt;
  logic              r_begin,      w_begin_nxt;
  logic              r_cmd_ready,  w_ready_nxt;
  logic              r_done,       w_done_nxt;
  logic              r_err,        w_err_nxt;
  logic [SC_W-1:0]   r_stall_cnt,  w_scnt_nxt;
  logic              r_stall_flag, w_flag_nxt;

  logic [IDX_W-1:0]  w_beat_inc;
  logic [7:0]        w_pattern;
  logic              w_len_ok;
  logic              w_accept;
  logic              w_last;

  assign w_beat_inc = r_beat + IDX_W'(1);
  assign w_len_ok   = (cmd_len != '0) && (cmd_len <= BCNT_W'(MAX_BURST));
  assign w_accept   = r_write && !avm_waitrequest;
  assign w_last     = (BCNT_W'(r_beat) == (r_len - BCNT_W'(1)));

  pattern_rotator #(
    .IDX_W (IDX_W)
  ) u_rot (
    .i_seed    (r_seed),
    .i_idx     (w_beat_inc),
    .o_pattern (w_pattern)
  );

  // Every output is a register loaded with its next-cycle value, so
  // waitrequest only ever reaches outputs through a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_len_nxt   = r_len;
    w_seed_nxt  = r_seed;
    w_beat_nxt  = r_beat;
    w_data_nxt  = r_data;
    w_write_nxt = r_write;
    w_begin_nxt = 1'b0;
    w_ready_nxt = r_cmd_ready;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_scnt_nxt  = r_stall_cnt;
    w_flag_nxt  = r_stall_flag;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (w_len_ok) begin
            w_state_nxt = ST_FIRST;
            w_addr_nxt  = cmd_addr;
            w_len_nxt   = cmd_len;
            w_seed_nxt  = cmd_seed;
            w_beat_nxt  = '0;
            w_data_nxt  = cmd_seed;
            w_write_nxt = 1'b1;
            w_begin_nxt = 1'b1;
            w_ready_nxt = 1'b0;
            w_scnt_nxt  = '0;
            w_flag_nxt  = 1'b0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_FIRST, ST_BURST: begin
        if (w_accept) begin
          w_scnt_nxt = '0;
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_write_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_BURST;
            w_beat_nxt  = w_beat_inc;
            w_data_nxt  = w_pattern;
          end
        end else begin
          // Stalled beat: count, flag at the limit, but never abort.
          if (r_stall_cnt < SC_W'(STALL_LIMIT)) begin
            w_scnt_nxt = r_stall_cnt + SC_W'(1);
          end
          if (r_stall_cnt >= SC_W'(STALL_LIMIT - 1)) begin
            w_flag_nxt = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_write_nxt = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_seed       <= '0;
      r_beat       <= '0;
      r_data       <= '0;
      r_write      <= 1'b0;
      r_begin      <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_len        <= w_len_nxt;
      r_seed       <= w_seed_nxt;
      r_beat       <= w_beat_nxt;
      r_data       <= w_data_nxt;
      r_write      <= w_write_nxt;
      r_begin      <= w_begin_nxt;
      r_cmd_ready  <= w_ready_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_stall_cnt  <= w_scnt_nxt;
      r_stall_flag <= w_flag_nxt;
    end
  end

  assign cmd_ready              = r_cmd_ready;
  assign avm_address            = r_addr;
  assign avm_write              = r_write;
  assign avm_writedata          = {{(DATA_W-8){1'b0}}, r_data};
  assign avm_byteenable         = '1;
  assign avm_burstcount         = r_len;
  assign avm_beginbursttransfer = r_begin;
  assign done                   = r_done;
  assign err_len                = r_err;
  assign stall_flag             = r_stall_flag;
  assign o_dbg_state            = r_state;

endmodule
